unsaved_irq_ctrl: RTL and testbench
===================================

UNSAVED_IRQ_CTRL -- requirements
Module: unsaved_irq_ctrl

Interface
REQ-001 clk  input  1  system clock; all state updates on rising edge.
REQ-002 reset_n  input  1  asynchronous, active-low reset; assertion clears all state immediately, release is synchronous to clk.
REQ-003 address  input  3  Avalon-MM slave word address.
REQ-004 chipselect  input  1  slave select.
REQ-005 write_n  input  1  active-low write; write strobe = chipselect && ~write_n.
REQ-006 writedata  input  16  write data.
REQ-007 readdata  output  16  registered read data.
REQ-008 irq_in  input  8  asynchronous interrupt sources; bit 0 is the timer irq, bits 1-7 are peripheral irqs.
REQ-009 irq  output  1  registered, active-high, aggregated interrupt to the CPU.

Function
REQ-010 Each irq_in bit SHALL pass through a 2-flop synchronizer; sync_in is the second-stage value, and sync_d is sync_in delayed by 1 cycle.
REQ-011 Source i event: level mode = sync_in[i]; edge mode = sync_in[i] & ~sync_d[i].
REQ-012 pending[i] SHALL set on event; in level mode pending[i] SHALL follow sync_in[i] unless the event is cleared by a W1C write while the level is low.
REQ-013 A write to addr 0 SHALL clear pending[i] for each writedata[i]=1 (W1C); a simultaneous event on the same bit SHALL win (pending stays 1).
REQ-014 Register map: 0 pending[7:0] R/W1C; 1 mask[7:0] R/W (1=enabled); 2 edge_sel[7:0] R/W (1=edge); 3 active R; 4 event_count[15:0] R, any write clears; 5 sync_in[7:0] R; 6-7 read 0, writes ignored; bits 15:8 read 0 unless stated otherwise.
REQ-015 active = {found, 12'b0, id[2:0]}: id is the lowest index i with pending[i]&mask[i]; found=0 and id=0 when none.
REQ-016 irq SHALL equal |(pending & mask) registered once: 1 cycle after pending/mask change.
REQ-017 readdata SHALL be registered every cycle from the address mux, independent of chipselect, giving 1-cycle read latency.
REQ-018 event_count SHALL increment by the number of source bits whose pending goes 0->1 that cycle (0-8), SHALL saturate at 16'hFFFF, and a clear-write SHALL take priority over increment.
REQ-019 Mask/edge_sel writes SHALL take effect on the next cycle; masking SHALL NOT alter pending.
REQ-020 Changing edge_sel[i] SHALL NOT alter pending[i]; the new mode SHALL apply from the next cycle.

Reset
REQ-021 On reset_n=0: synchronizers, sync_d, pending, event_count, readdata and irq SHALL be 0; mask SHALL be 8'h01 (timer enabled); edge_sel SHALL be 8'h01 (timer edge).
REQ-022 Reset asserted mid-operation SHALL discard any in-flight write or pending event; no event SHALL be generated on release from inputs already high in level mode until sync completes (2 cycles).

Configuration
REQ-023 Macro UNSAVED_IRQ_EDGE_EN defined: per-source edge/level selection is implemented as specified.
REQ-024 Macro UNSAVED_IRQ_EDGE_EN undefined: edge_sel SHALL read 8'h00, writes to it SHALL be ignored, and all sources SHALL be level mode; the sync_d register SHALL be omitted.

Verification
REQ-025 Reset, read addr 1 and addr 2 -> readdata 16'h0001 both, 1 cycle after address presented; irq=0.
REQ-026 Pulse irq_in[0] high for 1 cycle (edge mode, mask=1) -> pending=8'h01 after 3 cycles, irq=1 one cycle later, addr 3 reads 16'h8000; write 16'h0001 to addr 0 -> irq=0 after 2 cycles.
REQ-027 Hold irq_in[5]=1 with mask=8'h20 and edge_sel=0, write W1C 16'h0020 -> pending[5] stays 1 and irq stays 1; drop input and then W1C -> pending=0 and irq=0.
REQ-028 Set pending 8'h0C with mask 8'h08 -> active=16'h8003; mask 8'h00 -> irq=0 and pending still 8'h0C.
REQ-029 Edge on source 2 in the same cycle as a W1C of bit 2 -> pending[2]=1 and event_count +1.
REQ-030 Preload event_count to 16'hFFFE via events, then inject 3 events -> count 16'hFFFF; write addr 4 -> 16'h0000; with macro undefined, write 16'h00FF to addr 2 -> reads 16'h0000.

Source files
------------

// File: rtl/unsaved_irq_ctrl.sv
// Eight-source interrupt controller with an Avalon-MM register file: synchronizers, sticky pending,
// masking, lowest-index priority id, saturating event counter. Define UNSAVED_IRQ_EDGE_EN for edge/level select.
module unsaved_irq_ctrl (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [2:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [15:0] writedata,
    output logic [15:0] readdata,
    input  logic [7:0]  irq_in,
    output logic        irq
);

    logic        wr_en;
    logic [7:0]  sync_meta;
    logic [7:0]  sync_in;
    logic [7:0]  pending;
    logic [7:0]  mask;
    logic [7:0]  edge_sel;
    logic [7:0]  evt;
    logic [7:0]  w1c;
    logic [7:0]  pending_nxt;
    logic [7:0]  rise;
    logic [7:0]  hit;
    logic [3:0]  rise_cnt;
    logic [16:0] count_sum;
    logic [15:0] event_count;
    logic [15:0] active;
    logic [15:0] rd_mux;
    logic [2:0]  id;
    logic        found;
    logic        unused_wdata_hi;

    assign wr_en           = chipselect & ~write_n;
    assign unused_wdata_hi = ^writedata[15:8];

`ifdef UNSAVED_IRQ_EDGE_EN
    logic [7:0] sync_d;
    logic [7:0] edge_sel_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_d     <= 8'h00;
            edge_sel_q <= 8'h01;
        end else begin
            sync_d <= sync_in;
            if (wr_en && address == 3'd2)
                edge_sel_q <= writedata[7:0];
        end
    end

    assign edge_sel = edge_sel_q;
    assign evt      = (sync_in & ~sync_d & edge_sel) | (sync_in & ~edge_sel);
`else
    assign edge_sel = 8'h00;
    assign evt      = sync_in;
`endif

    // An event in the same cycle as its W1C wins, so a held level cannot be cleared.
    always_comb begin
        w1c = 8'h00;
        if (wr_en && address == 3'd0)
            w1c = writedata[7:0];
        pending_nxt = evt | (pending & ~w1c);
        rise        = pending_nxt & ~pending;
        rise_cnt    = 4'd0;
        for (int i = 0; i < 8; i++)
            rise_cnt = rise_cnt + {3'b000, rise[i]};
        count_sum = {1'b0, event_count} + {13'b0, rise_cnt};
    end

    always_comb begin
        hit   = pending & mask;
        found = |hit;
        id    = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (hit[i])
                id = 3'(i);
        end
        active = {found, 12'b0, id};
    end

    always_comb begin
        rd_mux = 16'h0000;
        case (address)
            3'd0:    rd_mux = {8'h00, pending};
            3'd1:    rd_mux = {8'h00, mask};
            3'd2:    rd_mux = {8'h00, edge_sel};
            3'd3:    rd_mux = active;
            3'd4:    rd_mux = event_count;
            3'd5:    rd_mux = {8'h00, sync_in};
            default: rd_mux = 16'h0000;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_meta   <= 8'h00;
            sync_in     <= 8'h00;
            pending     <= 8'h00;
            mask        <= 8'h01;
            event_count <= 16'h0000;
            readdata    <= 16'h0000;
            irq         <= 1'b0;
        end else begin
            sync_meta <= irq_in;
            sync_in   <= sync_meta;
            pending   <= pending_nxt;
            readdata  <= rd_mux;
            irq       <= |(pending & mask);
            if (wr_en && address == 3'd1)
                mask <= writedata[7:0];
            if (wr_en && address == 3'd4)
                event_count <= 16'h0000;
            else if (count_sum[16])
                event_count <= 16'hFFFF;
            else
                event_count <= count_sum[15:0];
        end
    end

endmodule

// File: tb/tb_unsaved_irq_ctrl.sv
// Self-checking bench for unsaved_irq_ctrl: directed vector table, hand-written corner sequences
// and randomized traffic compared every cycle against a behavioural model.
module tb_unsaved_irq_ctrl;

`ifdef UNSAVED_IRQ_EDGE_EN
    localparam bit HAS_EDGE = 1'b1;
`else
    localparam bit HAS_EDGE = 1'b0;
`endif
    localparam logic [7:0] EDGE_RST = HAS_EDGE ? 8'h01 : 8'h00;

    logic        clk;
    logic        reset_n;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [15:0] writedata;
    logic [15:0] readdata;
    logic [7:0]  irq_in;
    logic        irq;

    unsaved_irq_ctrl dut (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(readdata),
        .irq_in(irq_in), .irq(irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model state; hist[0] is the input seen at the last edge, hist[1] the synchronized level.
    logic [7:0]  hist [3];
    logic [7:0]  m_pend, m_mask, m_es;
    int          m_cnt;
    logic [7:0]  src;

    typedef struct {
        logic [2:0]  addr;
        logic        wr;
        logic [15:0] wd;
        logic [7:0]  src;
        logic [15:0] exp_rd;
        logic        exp_irq;
    } vec_t;
    vec_t tbl [10];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 3; i++) hist[i] = 8'h00;
        m_pend = 8'h00;
        m_mask = 8'h01;
        m_es   = EDGE_RST;
        m_cnt  = 0;
    endtask

    function automatic logic [15:0] model_read(input logic [2:0] a);
        logic [7:0] h;
        h = m_pend & m_mask;
        case (a)
            3'd0: return {8'h00, m_pend};
            3'd1: return {8'h00, m_mask};
            3'd2: return {8'h00, m_es};
            3'd3: begin
                for (int i = 0; i < 8; i++)
                    if (h[i]) return 16'h8000 + 16'(i);
                return 16'h0000;
            end
            3'd4: return 16'(m_cnt);
            3'd5: return {8'h00, hist[1]};
            default: return 16'h0000;
        endcase
    endfunction

    task automatic step(input logic [2:0] a, input logic wr, input logic [15:0] d);
        logic [15:0] exp_rd;
        logic        exp_irq;
        logic [7:0]  np;
        int          rises;
        address    = a;
        chipselect = wr ? 1'b1 : ($urandom_range(0, 1) == 1);
        write_n    = ~wr;
        writedata  = d;
        irq_in     = src;
        exp_rd  = model_read(a);
        exp_irq = |(m_pend & m_mask);
        rises   = 0;
        for (int i = 0; i < 8; i++) begin
            bit ev;
            ev = m_es[i] ? (hist[1][i] && !hist[2][i]) : hist[1][i];
            if (ev)                            np[i] = 1'b1;
            else if (wr && a == 3'd0 && d[i])  np[i] = 1'b0;
            else                               np[i] = m_pend[i];
            if (np[i] && !m_pend[i]) rises++;
        end
        @(posedge clk);
        #1;
        if (wr && a == 3'd4)  m_cnt = 0;
        else                  m_cnt = (m_cnt + rises > 65535) ? 65535 : m_cnt + rises;
        if (wr && a == 3'd1)  m_mask = d[7:0];
        if (wr && a == 3'd2 && HAS_EDGE) m_es = d[7:0];
        m_pend  = np;
        hist[2] = hist[1];
        hist[1] = hist[0];
        hist[0] = src;
        check("model_readdata", readdata, exp_rd);
        check("model_irq", {15'b0, irq}, {15'b0, exp_irq});
    endtask

    task automatic wr_reg(input logic [2:0] a, input logic [15:0] d);
        step(a, 1'b1, d);
    endtask

    task automatic rd_reg(input logic [2:0] a);
        step(a, 1'b0, 16'h0000);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        #1;
        check("reset_readdata", readdata, 16'h0000);
        check("reset_irq", {15'b0, irq}, 16'h0000);
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        int guard;
        bit tog;
        address = 3'd0; chipselect = 1'b0; write_n = 1'b1; writedata = 16'h0; irq_in = 8'h0;
        src = 8'h00;
        reset_n = 1'b1;
        model_reset();
        #2;
        do_reset();

        tbl[0] = '{3'd1, 1'b0, 16'h0000, 8'h00, 16'h0001,            1'b0};
        tbl[1] = '{3'd2, 1'b0, 16'h0000, 8'h00, {8'h00, EDGE_RST},    1'b0};
        tbl[2] = '{3'd0, 1'b0, 16'h0000, 8'h01, 16'h0000,            1'b0};
        tbl[3] = '{3'd0, 1'b0, 16'h0000, 8'h00, 16'h0000,            1'b0};
        tbl[4] = '{3'd0, 1'b0, 16'h0000, 8'h00, 16'h0000,            1'b0};
        tbl[5] = '{3'd0, 1'b0, 16'h0000, 8'h00, 16'h0001,            1'b1};
        tbl[6] = '{3'd3, 1'b0, 16'h0000, 8'h00, 16'h8000,            1'b1};
        tbl[7] = '{3'd4, 1'b0, 16'h0000, 8'h00, 16'h0001,            1'b1};
        tbl[8] = '{3'd0, 1'b1, 16'h0001, 8'h00, 16'h0001,            1'b1};
        tbl[9] = '{3'd0, 1'b0, 16'h0000, 8'h00, 16'h0000,            1'b0};
        for (int v = 0; v < 10; v++) begin
            src = tbl[v].src;
            step(tbl[v].addr, tbl[v].wr, tbl[v].wd);
            check($sformatf("vec%0d_readdata", v), readdata, tbl[v].exp_rd);
            check($sformatf("vec%0d_irq", v), {15'b0, irq}, {15'b0, tbl[v].exp_irq});
        end

        // Held level cannot be cleared; clears once the level has dropped.
        wr_reg(3'd2, 16'h0000);
        wr_reg(3'd1, 16'h0020);
        src = 8'h20;
        repeat (4) rd_reg(3'd0);
        wr_reg(3'd0, 16'h0020);
        rd_reg(3'd0);
        check("level_w1c_held_pending", readdata, 16'h0020);
        check("level_w1c_held_irq", {15'b0, irq}, 16'h0001);
        src = 8'h00;
        repeat (3) rd_reg(3'd0);
        wr_reg(3'd0, 16'h0020);
        rd_reg(3'd0);
        check("level_w1c_low_pending", readdata, 16'h0000);
        check("level_w1c_low_irq", {15'b0, irq}, 16'h0000);

        // Priority id and masking without touching pending.
        src = 8'h0C;
        rd_reg(3'd0);
        src = 8'h00;
        repeat (4) rd_reg(3'd0);
        wr_reg(3'd1, 16'h0008);
        rd_reg(3'd3);
        check("active_id3", readdata, 16'h8003);
        wr_reg(3'd1, 16'h0000);
        rd_reg(3'd0);
        check("masked_pending", readdata, 16'h000C);
        check("masked_irq", {15'b0, irq}, 16'h0000);
        wr_reg(3'd0, 16'h00FF);
        wr_reg(3'd1, 16'h00FF);

        // Event coinciding with a W1C of the same bit.
        wr_reg(3'd4, 16'h0000);
        if (HAS_EDGE) wr_reg(3'd2, 16'h0004);
        src = 8'h04;
        rd_reg(3'd0);
        rd_reg(3'd0);
        wr_reg(3'd0, 16'h0004);
        rd_reg(3'd0);
        check("race_pending", readdata, 16'h0004);
        rd_reg(3'd4);
        check("race_count", readdata, 16'h0001);
        src = 8'h00;
        repeat (3) rd_reg(3'd0);
        wr_reg(3'd0, 16'h00FF);
        wr_reg(3'd2, 16'h0000);

        // Drive the counter up to saturation.
        guard = 0;
        tog = 1'b1;
        while (m_cnt < 16'hFFF0 && guard < 20000) begin
            src = tog ? 8'hFF : 8'h00;
            tog = ~tog;
            wr_reg(3'd0, 16'h00FF);
            guard++;
        end
        check("preload_bulk_timeout", {15'b0, guard >= 20000}, 16'h0000);
        guard = 0;
        while (m_cnt < 16'hFFFE && guard < 200) begin
            src = tog ? 8'h01 : 8'h00;
            tog = ~tog;
            wr_reg(3'd0, 16'h00FF);
            guard++;
        end
        check("preload_fine_timeout", {15'b0, guard >= 200}, 16'h0000);
        src = 8'h00;
        repeat (4) wr_reg(3'd0, 16'h00FF);
        src = 8'h07;
        rd_reg(3'd0);
        src = 8'h00;
        repeat (4) rd_reg(3'd0);
        rd_reg(3'd4);
        check("count_saturated", readdata, 16'hFFFF);
        wr_reg(3'd4, 16'h1234);
        rd_reg(3'd4);
        check("count_cleared", readdata, 16'h0000);
        wr_reg(3'd2, 16'h00FF);
        rd_reg(3'd2);
        check("edge_sel_write", readdata, HAS_EDGE ? 16'h00FF : 16'h0000);
        wr_reg(3'd0, 16'h00FF);

        // Randomized traffic with a reset in the middle.
        for (int n = 0; n < 1500; n++) begin
            if (n == 700) do_reset();
            if ($urandom_range(0, 3) == 0) src = 8'($urandom);
            if ($urandom_range(0, 3) == 0)
                wr_reg(3'($urandom_range(0, 7)), 16'($urandom));
            else
                rd_reg(3'($urandom_range(0, 7)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
